// File: rtl/gemm_result_drain_pkg.sv
// gemm_result_drain_pkg: shared state type, widths and count check for the C-matrix drain
package mp_types;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } drain_state_e;

    localparam int DATA_W = 32;

    function automatic logic count_in_range(input logic [31:0] count, input int max_elems);
        return (count != 32'd0) && (count <= 32'(max_elems));
    endfunction

endpackage

// File: rtl/gemm_result_drain_if.sv
// gemm_result_drain_if: control, C-memory read port and output stream of the drain; m_row_last exists only with DRAIN_ROW_LAST_EN
interface gemm_result_drain_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [15:0]       M;
    logic [15:0]       Ncols;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_data;
    logic              m_last;
`ifdef DRAIN_ROW_LAST_EN
    logic              m_row_last;

    modport master (
        input  start, M, Ncols, rd_data, m_ready,
        output busy, done, err, rd_en, rd_addr, m_valid, m_data, m_last, m_row_last
    );

    modport slave (
        output start, M, Ncols, rd_data, m_ready,
        input  busy, done, err, rd_en, rd_addr, m_valid, m_data, m_last, m_row_last
    );
`else
    modport master (
        input  start, M, Ncols, rd_data, m_ready,
        output busy, done, err, rd_en, rd_addr, m_valid, m_data, m_last
    );

    modport slave (
        output start, M, Ncols, rd_data, m_ready,
        input  busy, done, err, rd_en, rd_addr, m_valid, m_data, m_last
    );
`endif
endinterface

// File: rtl/gemm_result_drain_fifo.sv
// drain_fifo2: two-entry FIFO holding read data with its end-of-matrix/end-of-row tags
module drain_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_data  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // write slot, read/write pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/gemm_result_drain.sv
// gemm_result_drain: reads an M x Ncols C matrix row-major and streams it out; define DRAIN_ROW_LAST_EN to add m_row_last
module gemm_result_drain
    import mp_types::*;
#(
    parameter int MAX_ELEMS = 65536,
    parameter int ADDR_W    = $clog2(MAX_ELEMS)
) (
    input logic                 clk,
    input logic                 rst,
    gemm_result_drain_if.master bus
);
`ifdef DRAIN_ROW_LAST_EN
    localparam int TAG_W = 2;
`else
    localparam int TAG_W = 1;
`endif
    localparam int FW = DATA_W + TAG_W;

    drain_state_e      r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_rd_en;
    logic              r_rd_last;
    logic              r_inf;
    logic              r_inf_last;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [31:0]       r_left;

    logic [31:0]       w_count;
    logic              w_count_ok;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_valid;
    logic              w_last_hs;
    logic [1:0]        w_occ_next;
    logic [FW-1:0]     w_fifo_in;
    logic [FW-1:0]     w_fifo_out;
    logic [FW-1:0]     w_head;

    assign w_count    = {16'd0, bus.M} * {16'd0, bus.Ncols};
    assign w_count_ok = count_in_range(w_count, MAX_ELEMS);

    // Read data lands one cycle after rd_en; it bypasses the FIFO when the FIFO is empty and downstream takes it
    assign w_valid    = !w_empty || r_inf;
    assign w_head     = w_empty ? (r_inf ? w_fifo_in : '0) : w_fifo_out;
    assign w_pop      = !w_empty && bus.m_ready;
    assign w_push     = r_inf && !(w_empty && bus.m_ready);
    assign w_last_hs  = w_valid && bus.m_ready && w_head[FW-1];

    // Occupancy after this edge plus the read now on the bus must leave room, so nothing is ever dropped
    assign w_occ_next = {w_full, !w_full && !w_empty} + 2'(w_push) - 2'(w_pop);
    assign w_issue    = (r_state == RUN) && (r_left != 32'd0) && ((w_occ_next + 2'(r_rd_en)) < 2'd2);

`ifdef DRAIN_ROW_LAST_EN
    logic [15:0] r_ncols;
    logic [15:0] r_col;
    logic        r_rd_row;
    logic        r_inf_row;
    logic [15:0] w_col_next;

    assign w_col_next = (r_col == r_ncols - 16'd1) ? 16'd0 : r_col + 16'd1;
    assign w_fifo_in  = {r_inf_last, r_inf_row, bus.rd_data};
    assign bus.m_row_last = w_head[DATA_W];

    // column of the read being issued, so its end-of-row tag follows the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ncols   <= 16'd0;
            r_col     <= 16'd0;
            r_rd_row  <= 1'b0;
            r_inf_row <= 1'b0;
        end else begin
            r_inf_row <= r_rd_row;
            if (r_state == IDLE && bus.start) begin
                r_ncols  <= bus.Ncols;
                r_col    <= 16'd0;
                r_rd_row <= (bus.Ncols == 16'd1);
            end else if (w_issue) begin
                r_col    <= w_col_next;
                r_rd_row <= (w_col_next == r_ncols - 16'd1);
            end
        end
    end
`else
    assign w_fifo_in = {r_inf_last, bus.rd_data};
`endif

    drain_fifo2 #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_fifo_in),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.busy    = r_busy;
    assign bus.done    = r_done || w_last_hs;
    assign bus.err     = r_err;
    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_head[DATA_W-1:0];
    assign bus.m_last  = w_head[FW-1];

    // drain FSM: accept start, issue reads with flow control, finish on the last handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_last  <= 1'b0;
            r_inf      <= 1'b0;
            r_inf_last <= 1'b0;
            r_rd_addr  <= '0;
            r_left     <= 32'd0;
        end else begin
            r_done     <= 1'b0;
            r_inf      <= r_rd_en;
            r_inf_last <= r_rd_last;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_err <= (w_count > 32'(MAX_ELEMS));
                        if (w_count_ok) begin
                            r_state   <= RUN;
                            r_busy    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                            r_left    <= w_count - 32'd1;
                            r_rd_last <= (w_count == 32'd1);
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_rd_en <= w_issue;
                    if (w_issue) begin
                        r_left    <= r_left - 32'd1;
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        r_rd_last <= (r_left == 32'd1);
                    end
                    if (r_rd_en && r_rd_last)
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    r_rd_en <= 1'b0;
                    if (w_last_hs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_result_drain.sv
// tb_gemm_result_drain: directed drains against a queue model of the expected element stream
module tb_gemm_result_drain;

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic        row;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gemm_result_drain_if #(.ADDR_W(16)) bus ();

    gemm_result_drain #(.MAX_ELEMS(65536), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    beat_t       exp_q[$];
    logic [31:0] got[$];
    logic        got_row[$];
    beat_t       e;
    logic        exp_done;
    int          exp_addr = 0;
    int          exp_count = 0;
    int          quick_done_cyc = -10;
    int          first_cyc = -1;
    int          last_cyc = -1;
    int          done_cyc = -1;
    int          start_cyc = 0;
    int          n_reads = 0;
    int          r0;
    int          wt;
    logic        ok;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        ready_mode = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int          rp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory read port: data for a read seen in one cycle appears in the next
    initial begin
        logic        en;
        logic [15:0] a;
        bus.rd_data = 32'd0;
        forever begin
            @(negedge clk);
            en = bus.rd_en;
            a  = bus.rd_addr;
            @(posedge clk);
            #1;
            bus.rd_data = en ? mem[a] : 32'hDEAD_BEEF;
        end
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = ready_mode ? pat[rp % 4] : 1'b1;
            rp++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            exp_done = (cyc == quick_done_cyc);
            if (bus.rd_en) begin
                n_reads++;
                chk("rd_in_range", 32'(exp_addr < exp_count), 32'd1);
                chk("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
                exp_addr++;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.m_valid), 32'd1);
                chk("stall_data", bus.m_data, prev_data);
                chk("stall_last", 32'(bus.m_last), 32'(prev_last));
            end
            if (bus.m_valid) begin
                chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0 && bus.m_ready) begin
                    e = exp_q.pop_front();
                    chk("m_data", bus.m_data, e.d);
                    chk("m_last", 32'(bus.m_last), 32'(e.last));
`ifdef DRAIN_ROW_LAST_EN
                    chk("m_row_last", 32'(bus.m_row_last), 32'(e.row));
                    got_row.push_back(bus.m_row_last);
`endif
                    if (got.size() == 0)
                        first_cyc = cyc;
                    got.push_back(bus.m_data);
                    if (e.last) begin
                        exp_done = 1'b1;
                        last_cyc = cyc;
                    end
                end
            end
            chk("done", 32'(bus.done), 32'(exp_done));
            if (bus.done)
                done_cyc = cyc;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    task automatic do_start(input int m, input int n);
        int    cnt;
        beat_t b;
        cnt = m * n;
        got.delete();
        got_row.delete();
        first_cyc = -1;
        last_cyc  = -1;
        done_cyc  = -1;
        if (cnt > 0 && cnt <= 65536) begin
            for (int k = 0; k < cnt; k++) begin
                b.d    = mem[k];
                b.last = (k == cnt - 1);
                b.row  = ((k % n) == n - 1);
                exp_q.push_back(b);
            end
            exp_addr  = 0;
            exp_count = cnt;
        end else begin
            quick_done_cyc = cyc + 1;
        end
        bus.M     = 16'(m);
        bus.Ncols = 16'(n);
        bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, 32'(t < 2000), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_done"}, 32'(bus.done), 32'd0);
        chk({name, "_rd_en"}, 32'(bus.rd_en), 32'd0);
        chk({name, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
        chk({name, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        chk({name, "_m_last"}, 32'(bus.m_last), 32'd0);
        chk({name, "_m_data"}, bus.m_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = 32'(i);
        bus.start = 1'b0;
        bus.M     = 16'd0;
        bus.Ncols = 16'd0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        chk("reset_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_start(2, 3);
        wait_idle("a_timeout");
        chk("a_count", 32'(got.size()), 32'd6);
        ok = (got.size() == 6);
        for (int i = 0; i < got.size(); i++)
            ok = ok && (got[i] == 32'(i));
        chk("a_values", 32'(ok), 32'd1);
        chk("a_latency", 32'(first_cyc - start_cyc), 32'd2);
        chk("a_span", 32'(last_cyc - first_cyc), 32'd5);
        chk("a_done_cycle", 32'(done_cyc), 32'(last_cyc));

        ready_mode = 1'b1;
        do_start(4, 4);
        wait_idle("b_timeout");
        ready_mode = 1'b0;
        chk("b_count", 32'(got.size()), 32'd16);
        ok = (got.size() == 16);
        for (int i = 0; i < got.size(); i++)
            ok = ok && (got[i] == 32'(i));
        chk("b_values", 32'(ok), 32'd1);

        do_start(1, 1);
        wait_idle("c_timeout");
        chk("c_count", 32'(got.size()), 32'd1);
        chk("c_latency", 32'(first_cyc - start_cyc), 32'd2);
        chk("c_done_cycle", 32'(done_cyc), 32'(last_cyc));

        r0 = n_reads;
        do_start(0, 7);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_done_delay", 32'(done_cyc - start_cyc), 32'd1);
        chk("zero_reads", 32'(n_reads - r0), 32'd0);
        chk("zero_err", 32'(bus.err), 32'd0);

        r0 = n_reads;
        do_start(512, 256);
        repeat (3) @(posedge clk);
        #1;
        chk("big_err", 32'(bus.err), 32'd1);
        chk("big_done_delay", 32'(done_cyc - start_cyc), 32'd1);
        chk("big_reads", 32'(n_reads - r0), 32'd0);
        chk("big_busy", 32'(bus.busy), 32'd0);
        do_start(1, 2);
        chk("err_cleared", 32'(bus.err), 32'd0);
        wait_idle("e_timeout");
        chk("e_count", 32'(got.size()), 32'd2);

        for (int i = 0; i < 16; i++)
            mem[i] = 32'(1000 + i);
        do_start(4, 4);
        wt = 0;
        while (got.size() < 3 && wt < 100) begin
            @(posedge clk);
            #1;
            wt++;
        end
        chk("f_reach_elem3", 32'(got.size()), 32'd3);
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        do_start(2, 3);
        wait_idle("f_timeout");
        chk("f_count", 32'(got.size()), 32'd6);
        chk("f_first", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'd1000);

`ifdef DRAIN_ROW_LAST_EN
        do_start(3, 2);
        wait_idle("g_timeout");
        ok = (got_row.size() == 6);
        for (int i = 0; i < got_row.size(); i++)
            ok = ok && (got_row[i] == ((i % 2) == 1));
        chk("g_row_last_pattern", 32'(ok), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gemm_result_drain.md
GEMM_RESULT_DRAIN -- requirements
Module: gemm_result_drain

Interface
REQ-001 SHALL have parameter MAX_ELEMS, default 65536, meaning depth of the C result memory in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default $clog2(MAX_ELEMS), meaning the C memory address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  single-cycle request to drain the C matrix.
REQ-006 M  input  16  row count of C, sampled at accepted start.
REQ-007 Ncols  input  16  column count of C, sampled at accepted start.
REQ-008 busy  output  1  drain in progress.
REQ-009 done  output  1  one-cycle pulse when the last element is accepted downstream.
REQ-010 err  output  1  sticky flag: M*Ncols exceeded MAX_ELEMS; cleared by the next accepted start.
REQ-011 rd_en  output  1  read strobe to the C memory read port.
REQ-012 rd_addr  output  ADDR_W  C word address, row-major (r*Ncols+c).
REQ-013 rd_data  input  32  C read data, valid exactly 1 cycle after rd_en.
REQ-014 m_valid  output  1  output stream data valid.
REQ-015 m_ready  input  1  downstream ready.
REQ-016 m_data  output  32  C element.
REQ-017 m_last  output  1  marks the final element of the matrix.

Function
REQ-018 SHALL implement the FSM IDLE -> RUN -> FLUSH -> IDLE.
- IDLE->RUN on start when count=M*Ncols (32-bit product) satisfies 0<count<=MAX_ELEMS.
- RUN->FLUSH the cycle the last read issues.
- FLUSH->IDLE when the FIFO is empty and no read is in flight; done pulses on that final handshake cycle.
REQ-019 SHALL treat start with count==0 as a one-cycle done pulse, with no reads, no m_valid, and no err.
REQ-020 SHALL treat start with count>MAX_ELEMS as err=1 with a done pulse, no reads, and the FSM staying in IDLE.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL first assert rd_en (addr 0) in the cycle after start is sampled, and assert m_valid no earlier than 2 cycles after start.
REQ-023 SHALL buffer read data in a 2-entry FIFO and issue rd_en only when (FIFO occupancy + reads in flight) < 2, so no data is ever dropped.
REQ-024 SHALL sustain 1 element/cycle while m_ready is held high, after the initial latency.
REQ-025 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-026 SHALL assert m_last only with element index count-1.
REQ-027 SHALL increment rd_addr by 1 per issued read, with no wrap-around; the address range is bounded by REQ-020.

Reset
REQ-028 SHALL on rst drive FSM=IDLE, busy=0, done=0, err=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_data=0, and an empty FIFO.
REQ-029 SHALL abort a drain on rst mid-operation with no further m_valid or done, and discard the in-flight read.

Configuration
REQ-030 SHALL, when macro DRAIN_ROW_LAST_EN is defined, add output m_row_last (1 bit) asserted with the element at column Ncols-1 of every row, travelling through the FIFO with its data.
REQ-031 SHALL, without DRAIN_ROW_LAST_EN, omit the m_row_last port and its column counter entirely.

Structure
REQ-032 SHALL place typedef drain_state_e (IDLE, RUN, FLUSH) in package mp_types.
REQ-033 SHALL use one sub-module, drain_fifo2: a 2-entry FIFO of {last, row_last, data}, with push/pop/full/empty and a parameterised width.

Verification
REQ-034 M=2, Ncols=3, C=0..5, m_ready=1 -> m_data 0,1,2,3,4,5 on consecutive cycles, first beat at start+2, m_last on 5, done on the same cycle as beat 5.
REQ-035 M=4, Ncols=4, m_ready toggling 1,0,0,1 -> all 16 values in order, none duplicated or lost, and data stable while stalled.
REQ-036 M=0, Ncols=7 -> done 1 cycle after start, rd_en never asserted, err=0.
REQ-037 M=512, Ncols=256 with MAX_ELEMS=65536 -> err=1, done pulse, no reads; a subsequent valid start clears err.
REQ-038 rst asserted at element 3 of a 16-element drain -> all outputs return to reset values immediately; a new start drains from address 0.
REQ-039 With DRAIN_ROW_LAST_EN, M=3, Ncols=2 -> m_row_last on elements 1, 3 and 5.
